decode_hazard_ctrl: RTL and testbench
=====================================

Name: decode_hazard_ctrl

Overview:
- Parametrised decode-stage control block: owns the PC and the decode-to-execute instruction register.
- Detects RAW hazards against any number of downstream pipeline stages and issues per-source forwarding selects.
- Inserts configurable load-use bubbles, honours the cache freeze, and handles branch/jump redirect flushes.
- Sits between InstructionMemory/RegisterFile and Execute; replaces the fixed two-stage, one-bubble decode control.

Parameters:
- XLEN, 32, PC and data width.
- FWD_STAGES, 2, downstream stages that can forward (slot 0 = EXE, 1 = MEM, ...); legal range 2..4.
- LOAD_USE_STALLS, 1, bubbles needed between a load in EXE and a consumer; legal range 0..FWD_STAGES-1.
- PC_RESET, 0, PC value after reset.
- NOP, 32'h00000013, bubble instruction (addi x0,x0,0).
- FSEL_W, $clog2(FWD_STAGES+1), forward-select width (derived).

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- freeze_cpu  in  1  global stall from cache; holds all state
- flush  in  1  redirect request from Execute; source holds it until a non-frozen cycle
- redirect_pc  in  XLEN  target PC, valid with flush
- inst  in  32  fetched instruction at PC
- down_inst  in  (FWD_STAGES-1)*32  instructions in slots 1..FWD_STAGES-1, slot 1 in LSBs
- PC  out  XLEN  fetch address
- rd1, rd2  out  1  register-file read enables
- addr1, addr2  out  5  register-file read addresses (inst[19:15], inst[24:20])
- exe_inst  out  32  instruction issued to Execute (slot 0)
- exe_pc  out  XLEN  PC of exe_inst
- exe_rs1_forward, exe_rs2_forward  out  FSEL_W  0 = register file, k+1 = slot k
- stall_cycles  out  16  saturating count of load-use bubbles inserted

Behaviour:
- Reset, synchronous, applied on the clock edge:
  - PC=PC_RESET
  - exe_inst=NOP, exe_pc=0
  - both forward selects=0
  - stall_cycles=0
- Opcode classes (RV32I):
  - need_rs1: JALR, BRANCH, LOAD, STORE, OP_IMM, OP.
  - need_rs2: BRANCH, STORE, OP.
  - writes_rd: LUI, AUIPC, JAL, JALR, LOAD, OP_IMM, OP.
- Producer match for source s against slot k: need_s, src!=x0, writes_rd(slot k), rd(slot k)==src.
- Nearest match wins: lowest k has priority; sel=k+1 for the nearest match, else 0.
- Load-use hazard: nearest match for either source is a LOAD in slot k with k<LOAD_USE_STALLS.
  - Evaluated every cycle, so multi-bubble waits resolve naturally as the load advances.
  - LOAD_USE_STALLS=0 never stalls.
- rd1 = !freeze_cpu && need_rs1; rd2 = !freeze_cpu && need_rs2. Addresses always follow inst.
- Next-state priority, one cycle per decision:
  1. rst: reset values.
  2. freeze_cpu: hold PC, exe_inst, exe_pc, selects, stall_cycles.
  3. flush: PC<=redirect_pc, exe_inst<=NOP, exe_pc<=0, selects<=0; overrides a simultaneous hazard, and no bubble is counted.
  4. load-use hazard: PC held, exe_inst<=NOP, selects<=0, stall_cycles+=1 (saturating at 16'hFFFF).
  5. normal: exe_inst<=inst, exe_pc<=PC, selects<=computed values, PC<=PC+4 (mod 2^XLEN; wraps silently).
- Latency:
  - inst issues to exe_inst one edge after it is presented, unless stalled.
  - Forward selects are registered alongside exe_inst.
- Slot 0 is the internal exe_inst register. Slots >=1 come from down_inst, whose stages freeze in lock-step with this block.
- Reset mid-stall or mid-freeze returns to reset values; no pending bubble survives.

Decomposition:
- Shared package rv_pkg:
  - opcode localparams (OP_LUI ... OP_OP)
  - NOP constant
  - functions writes_rd, need_rs1, need_rs2 (also reused by Write_Back_Control)
- Sub-module hazard_match: one per source; compares one source register against FWD_STAGES slots and returns sel and is_load_hit.

Test Plan:
- Forwarding: defaults; addi x5,x0,7 then add x6,x5,x5 → exe_rs1_forward=exe_rs2_forward=1 when the add reaches exe_inst; with one independent inst between them → both =2.
- Load-use: LOAD_USE_STALLS=1; lw x5,0(x0) then add x6,x5,x0 → exactly one NOP in exe_inst, PC held for 1 cycle, add then issues with rs1 select=2, stall_cycles=1.
- Deep config: FWD_STAGES=3, LOAD_USE_STALLS=2, same lw/add pair → two consecutive NOPs, add issues with select=3, stall_cycles=2; a source of x0 never forwards or stalls.
- Freeze: freeze_cpu held 5 cycles mid-stream, including during a load-use bubble → PC, exe_inst, selects and stall_cycles unchanged throughout; after release the sequence matches the unfrozen run.
- Flush: flush=1, redirect_pc=0x100 coincident with a load-use hazard → next cycle PC=0x100, exe_inst=NOP, stall_cycles unchanged; then 0x104 on the following normal cycle.
- Reset: rst asserted mid-stall → next edge PC=0, exe_inst=0x00000013, selects=0, stall_cycles=0.

Source files
------------

// File: rtl/rv_pkg.sv
// RV32I opcode map and decode helpers shared by decode and write-back control.
// Classifies an opcode by which register operands it reads and writes.
package rv_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  function automatic logic writes_rd(input logic [6:0] op);
    return op inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
                      OP_LOAD, OP_OPIMM, OP_OP};
  endfunction

  function automatic logic need_rs1(input logic [6:0] op);
    return op inside {OP_JALR, OP_BRANCH, OP_LOAD,
                      OP_STORE, OP_OPIMM, OP_OP};
  endfunction

  function automatic logic need_rs2(input logic [6:0] op);
    return op inside {OP_BRANCH, OP_STORE, OP_OP};
  endfunction

  function automatic logic is_load(input logic [6:0] op);
    return op == OP_LOAD;
  endfunction

endpackage

// File: rtl/hazard_match.sv
// Compares one source register against every downstream slot.
// The nearest producer wins; a load there within the bubble window flags a hit.
module hazard_match
  import rv_pkg::*;
#(
  parameter int FWD_STAGES      = 2,
  parameter int LOAD_USE_STALLS = 1,
  parameter int FSEL_W          = $clog2(FWD_STAGES + 1)
) (
  input  logic                     need,
  input  logic [4:0]               src,
  input  logic [FWD_STAGES*32-1:0] slots,
  output logic [FSEL_W-1:0]        sel,
  output logic                     is_load_hit
);

  logic unused_slot_bits;
  assign unused_slot_bits = ^slots;

  // Walk farthest to nearest so the lowest slot overwrites the result.
  always_comb begin
    sel         = '0;
    is_load_hit = 1'b0;
    for (int k = FWD_STAGES - 1; k >= 0; k--) begin
      if (need && src != 5'd0
          && writes_rd(slots[k*32 +: 7])
          && slots[k*32+7 +: 5] == src) begin
        sel         = FSEL_W'(k + 1);
        is_load_hit = is_load(slots[k*32 +: 7])
                      && (k < LOAD_USE_STALLS);
      end
    end
  end

endmodule

// File: rtl/decode_hazard_ctrl.sv
// Decode-stage control: PC, decode-to-execute register, forwarding selects,
// load-use bubbles, cache freeze and redirect flush.
module decode_hazard_ctrl
  import rv_pkg::*;
#(
  parameter int              XLEN            = 32,
  parameter int              FWD_STAGES      = 2,
  parameter int              LOAD_USE_STALLS = 1,
  parameter logic [XLEN-1:0] PC_RESET        = '0,
  parameter logic [31:0]     NOP             = NOP_INST,
  parameter int              FSEL_W          = $clog2(FWD_STAGES + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         freeze_cpu,
  input  logic                         flush,
  input  logic [XLEN-1:0]              redirect_pc,
  input  logic [31:0]                  inst,
  input  logic [(FWD_STAGES-1)*32-1:0] down_inst,
  output logic [XLEN-1:0]              PC,
  output logic                         rd1,
  output logic                         rd2,
  output logic [4:0]                   addr1,
  output logic [4:0]                   addr2,
  output logic [31:0]                  exe_inst,
  output logic [XLEN-1:0]              exe_pc,
  output logic [FSEL_W-1:0]            exe_rs1_forward,
  output logic [FSEL_W-1:0]            exe_rs2_forward,
  output logic [15:0]                  stall_cycles
);

  logic [XLEN-1:0]   pc_q, pc_d;
  logic [31:0]       exe_inst_q, exe_inst_d;
  logic [XLEN-1:0]   exe_pc_q, exe_pc_d;
  logic [FSEL_W-1:0] fwd1_q, fwd1_d;
  logic [FSEL_W-1:0] fwd2_q, fwd2_d;
  logic [15:0]       stall_q, stall_d;

  logic                     need1, need2;
  logic [FSEL_W-1:0]        sel1, sel2;
  logic                     hit1, hit2, hazard;
  logic [FWD_STAGES*32-1:0] slots;

  assign need1 = need_rs1(inst[6:0]);
  assign need2 = need_rs2(inst[6:0]);
  assign slots = {down_inst, exe_inst_q};

  hazard_match #(
    .FWD_STAGES      (FWD_STAGES),
    .LOAD_USE_STALLS (LOAD_USE_STALLS),
    .FSEL_W          (FSEL_W)
  ) u_rs1 (
    .need        (need1),
    .src         (inst[19:15]),
    .slots       (slots),
    .sel         (sel1),
    .is_load_hit (hit1)
  );

  hazard_match #(
    .FWD_STAGES      (FWD_STAGES),
    .LOAD_USE_STALLS (LOAD_USE_STALLS),
    .FSEL_W          (FSEL_W)
  ) u_rs2 (
    .need        (need2),
    .src         (inst[24:20]),
    .slots       (slots),
    .sel         (sel2),
    .is_load_hit (hit2)
  );

  assign hazard = hit1 | hit2;

  always_comb begin
    pc_d       = pc_q;
    exe_inst_d = exe_inst_q;
    exe_pc_d   = exe_pc_q;
    fwd1_d     = fwd1_q;
    fwd2_d     = fwd2_q;
    stall_d    = stall_q;
    if (!freeze_cpu) begin
      if (flush) begin
        pc_d       = redirect_pc;
        exe_inst_d = NOP;
        exe_pc_d   = '0;
        fwd1_d     = '0;
        fwd2_d     = '0;
      end else if (hazard) begin
        exe_inst_d = NOP;
        fwd1_d     = '0;
        fwd2_d     = '0;
        if (stall_q != 16'hFFFF)
          stall_d = stall_q + 16'd1;
      end else begin
        pc_d       = pc_q + XLEN'(4);
        exe_inst_d = inst;
        exe_pc_d   = pc_q;
        fwd1_d     = sel1;
        fwd2_d     = sel2;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= PC_RESET;
      exe_inst_q <= NOP;
      exe_pc_q   <= '0;
      fwd1_q     <= '0;
      fwd2_q     <= '0;
      stall_q    <= '0;
    end else begin
      pc_q       <= pc_d;
      exe_inst_q <= exe_inst_d;
      exe_pc_q   <= exe_pc_d;
      fwd1_q     <= fwd1_d;
      fwd2_q     <= fwd2_d;
      stall_q    <= stall_d;
    end
  end

  assign PC              = pc_q;
  assign rd1             = !freeze_cpu && need1;
  assign rd2             = !freeze_cpu && need2;
  assign addr1           = inst[19:15];
  assign addr2           = inst[24:20];
  assign exe_inst        = exe_inst_q;
  assign exe_pc          = exe_pc_q;
  assign exe_rs1_forward = fwd1_q;
  assign exe_rs2_forward = fwd2_q;
  assign stall_cycles    = stall_q;

endmodule

// File: tb/tb_decode_hazard_ctrl.sv
// Directed bench: default (2 fwd, 1 bubble) and deep (3 fwd, 2 bubble) configs
// fed from a shared instruction memory with lock-step downstream slot models.
module tb_decode_hazard_ctrl;

  localparam logic [31:0] NOPI      = 32'h0000_0013;
  localparam logic [31:0] ADDI_X5   = 32'h0070_0293;
  localparam logic [31:0] ADD_X6_55 = 32'h0052_8333;
  localparam logic [31:0] ADDI_X7   = 32'h0010_0393;
  localparam logic [31:0] LW_X5     = 32'h0000_2283;
  localparam logic [31:0] ADD_X6_50 = 32'h0002_8333;
  localparam logic [31:0] LW_X0     = 32'h0000_2003;
  localparam logic [31:0] ADD_X6_00 = 32'h0000_0333;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        freeze_cpu = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] imem [0:127];

  logic [31:0] inst_a, pc_a, exe_a, epc_a, down_a;
  logic        rd1_a, rd2_a;
  logic [4:0]  addr1_a, addr2_a;
  logic [1:0]  f1_a, f2_a;
  logic [15:0] st_a;

  logic [31:0] inst_b, pc_b, exe_b, epc_b;
  logic [63:0] down_b;
  logic        rd1_b, rd2_b;
  logic [4:0]  addr1_b, addr2_b;
  logic [1:0]  f1_b, f2_b;
  logic [15:0] st_b;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign inst_a = imem[pc_a[8:2]];
  assign inst_b = imem[pc_b[8:2]];

  always @(posedge clk)
    if (rst) down_a <= NOPI;
    else if (!freeze_cpu) down_a <= exe_a;

  always @(posedge clk)
    if (rst) down_b <= {NOPI, NOPI};
    else if (!freeze_cpu) down_b <= {down_b[31:0], exe_b};

  decode_hazard_ctrl dut_a (
    .clk             (clk),
    .rst             (rst),
    .freeze_cpu      (freeze_cpu),
    .flush           (flush),
    .redirect_pc     (redirect_pc),
    .inst            (inst_a),
    .down_inst       (down_a),
    .PC              (pc_a),
    .rd1             (rd1_a),
    .rd2             (rd2_a),
    .addr1           (addr1_a),
    .addr2           (addr2_a),
    .exe_inst        (exe_a),
    .exe_pc          (epc_a),
    .exe_rs1_forward (f1_a),
    .exe_rs2_forward (f2_a),
    .stall_cycles    (st_a)
  );

  decode_hazard_ctrl #(
    .FWD_STAGES      (3),
    .LOAD_USE_STALLS (2)
  ) dut_b (
    .clk             (clk),
    .rst             (rst),
    .freeze_cpu      (freeze_cpu),
    .flush           (flush),
    .redirect_pc     (redirect_pc),
    .inst            (inst_b),
    .down_inst       (down_b),
    .PC              (pc_b),
    .rd1             (rd1_b),
    .rd2             (rd2_b),
    .addr1           (addr1_b),
    .addr2           (addr2_b),
    .exe_inst        (exe_b),
    .exe_pc          (epc_b),
    .exe_rs1_forward (f1_b),
    .exe_rs2_forward (f2_b),
    .stall_cycles    (st_b)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    flush = 1'b0;
    freeze_cpu = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 128; i++) imem[i] = NOPI;
  endtask

  initial begin
    // forwarding program
    clear_imem();
    imem[0] = ADDI_X5;
    imem[1] = ADD_X6_55;
    imem[2] = ADDI_X5;
    imem[3] = ADDI_X7;
    imem[4] = ADD_X6_55;
    do_reset();
    chk("rst_pc",    pc_a, 32'h0);
    chk("rst_exe",   exe_a, NOPI);
    chk("rst_epc",   epc_a, 32'h0);
    chk("rst_f1",    32'(f1_a), 32'h0);
    chk("rst_f2",    32'(f2_a), 32'h0);
    chk("rst_stall", 32'(st_a), 32'h0);
    chk("rst_pc_b",  pc_b, 32'h0);

    tick();
    chk("e1_exe",   exe_a, ADDI_X5);
    chk("e1_rd1",   32'(rd1_a), 32'h1);
    chk("e1_rd2",   32'(rd2_a), 32'h1);
    chk("e1_addr1", 32'(addr1_a), 32'd5);
    chk("e1_addr2", 32'(addr2_a), 32'd5);
    tick();
    chk("fw1_exe", exe_a, ADD_X6_55);
    chk("fw1_epc", epc_a, 32'h4);
    chk("fw1_f1",  32'(f1_a), 32'd1);
    chk("fw1_f2",  32'(f2_a), 32'd1);
    tick();
    tick();
    tick();
    chk("fw2_exe", exe_a, ADD_X6_55);
    chk("fw2_epc", epc_a, 32'h10);
    chk("fw2_f1",  32'(f1_a), 32'd2);
    chk("fw2_f2",  32'(f2_a), 32'd2);

    // load-use, deep config, then flush during a hazard
    clear_imem();
    imem[0]  = LW_X5;
    imem[1]  = ADD_X6_50;
    imem[2]  = LW_X5;
    imem[3]  = ADD_X6_50;
    imem[64] = ADDI_X7;
    do_reset();
    tick();
    chk("lu_e1_exe", exe_a, LW_X5);
    tick();
    chk("lu_bub_exe", exe_a, NOPI);
    chk("lu_bub_pc",  pc_a, 32'h4);
    chk("lu_bub_st",  32'(st_a), 32'd1);
    chk("dp_b1_exe",  exe_b, NOPI);
    chk("dp_b1_st",   32'(st_b), 32'd1);
    tick();
    chk("lu_add_exe", exe_a, ADD_X6_50);
    chk("lu_add_f1",  32'(f1_a), 32'd2);
    chk("lu_add_f2",  32'(f2_a), 32'd0);
    chk("lu_add_pc",  pc_a, 32'h8);
    chk("lu_add_st",  32'(st_a), 32'd1);
    chk("dp_b2_exe",  exe_b, NOPI);
    chk("dp_b2_pc",   pc_b, 32'h4);
    chk("dp_b2_st",   32'(st_b), 32'd2);
    tick();
    chk("dp_add_exe", exe_b, ADD_X6_50);
    chk("dp_add_f1",  32'(f1_b), 32'd3);
    chk("dp_add_st",  32'(st_b), 32'd2);
    chk("fl_pre_exe", exe_a, LW_X5);
    flush = 1'b1;
    redirect_pc = 32'h100;
    tick();
    flush = 1'b0;
    chk("fl_pc",  pc_a, 32'h100);
    chk("fl_exe", exe_a, NOPI);
    chk("fl_epc", epc_a, 32'h0);
    chk("fl_st",  32'(st_a), 32'd1);
    tick();
    chk("fl2_pc",  pc_a, 32'h104);
    chk("fl2_exe", exe_a, ADDI_X7);
    chk("fl2_epc", epc_a, 32'h100);

    // freeze with a load-use hazard pending
    do_reset();
    tick();
    freeze_cpu = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("fz_pc",  pc_a, 32'h4);
      chk("fz_exe", exe_a, LW_X5);
      chk("fz_st",  32'(st_a), 32'd0);
      chk("fz_rd1", 32'(rd1_a), 32'd0);
    end
    freeze_cpu = 1'b0;
    tick();
    chk("fz_bub_exe", exe_a, NOPI);
    chk("fz_bub_pc",  pc_a, 32'h4);
    chk("fz_bub_st",  32'(st_a), 32'd1);
    tick();
    chk("fz_add_exe", exe_a, ADD_X6_50);
    chk("fz_add_f1",  32'(f1_a), 32'd2);
    chk("fz_add_pc",  pc_a, 32'h8);

    // reset in the middle of a two-bubble stall
    do_reset();
    tick();
    tick();
    chk("ms_pre_st", 32'(st_b), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("ms_pc",  pc_b, 32'h0);
    chk("ms_exe", exe_b, NOPI);
    chk("ms_f1",  32'(f1_b), 32'd0);
    chk("ms_st",  32'(st_b), 32'd0);
    tick();
    chk("ms_e1_exe", exe_b, LW_X5);
    chk("ms_e1_pc",  pc_b, 32'h4);

    // x0 as a destination/source never forwards or stalls
    imem[0] = LW_X0;
    imem[1] = ADD_X6_00;
    do_reset();
    tick();
    tick();
    chk("x0_exe", exe_b, ADD_X6_00);
    chk("x0_f1",  32'(f1_b), 32'd0);
    chk("x0_f2",  32'(f2_b), 32'd0);
    chk("x0_st",  32'(st_b), 32'd0);
    chk("x0_pc",  pc_b, 32'h8);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
